// File: rtl/vscpu_sys_ctrl_if.sv
// Host/core/RAM signal bundle for the VSCPU system controller.
// The slave modport is the controller's view; the master modport is the environment's view.
interface vscpu_sys_ctrl_if #(
    parameter int AW = 14,
    parameter int DW = 32
);
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          start;
    logic          stop;
    logic [31:0]   run_cycles;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic          cpu_rst;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          loaded;
    logic          load_err;
    logic          halted;
    logic [31:0]   cycles_run;

    modport slave (
        input  load_valid, load_data, load_last, start, stop, run_cycles,
               dbg_req, dbg_addr, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output load_ready, dbg_rdata, dbg_rvalid, cpu_rst, ram_we, ram_addr,
               ram_wdata, loaded, load_err, halted, cycles_run
    );

    modport master (
        output load_valid, load_data, load_last, start, stop, run_cycles,
               dbg_req, dbg_addr, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  load_ready, dbg_rdata, dbg_rvalid, cpu_rst, ram_we, ram_addr,
               ram_wdata, loaded, load_err, halted, cycles_run
    );
endinterface

// File: rtl/vscpu_sys_ctrl.sv
// VSCPU system controller: loads a program image into the shared RAM, runs the
// core for a bounded number of cycles, halts it and serves host debug reads.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | core in reset, waiting for load / start / debug read
// LOAD   | streaming image words into RAM, one per handshake
// RUN    | core out of reset, owns the RAM port
// HALT   | run finished, core in reset, RAM contents preserved
// DRD    | debug read data phase, returns to IDLE or HALT
module vscpu_sys_ctrl #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    vscpu_sys_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALT,
        S_DRD
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] ptr;
    logic [31:0]   budget_cnt;
    logic [31:0]   cycles_run;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic          drd_ret_halt;
    logic          loaded, load_err, halted;
    logic          load_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ptr_max;
    logic          run_done;

    assign ptr_max  = (ptr == '1);
    // budget_cnt counts down from the latched budget; terminal count 1 ends the run
    assign run_done = (budget_cnt == 32'd1) || bus.stop;

    // Next-state decode and RAM port steering
    always_comb begin
        state_nx   = state;
        load_ready = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (state)
            S_IDLE, S_HALT: begin
                if (bus.load_valid) begin
                    state_nx = S_LOAD;
                end else if (bus.start) begin
                    if (loaded) state_nx = S_RUN;
                end else if (bus.dbg_req) begin
                    state_nx = S_DRD;
                    ram_addr = bus.dbg_addr;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (bus.load_valid) begin
                    ram_we    = 1'b1;
                    ram_addr  = ptr;
                    ram_wdata = bus.load_data;
                    if (bus.load_last || ptr_max) state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                ram_we    = bus.cpu_we;
                ram_addr  = bus.cpu_addr;
                ram_wdata = bus.cpu_wdata;
                if (run_done) state_nx = S_HALT;
            end
            S_DRD: begin
                state_nx = drd_ret_halt ? S_HALT : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Load pointer, run counters, status flags and debug capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            budget_cnt   <= '0;
            cycles_run   <= '0;
            dbg_rdata    <= '0;
            dbg_rvalid   <= 1'b0;
            drd_ret_halt <= 1'b0;
            loaded       <= 1'b0;
            load_err     <= 1'b0;
            halted       <= 1'b0;
        end else begin
            dbg_rvalid <= (state == S_DRD);
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.load_valid) begin
                        ptr      <= '0;
                        loaded   <= 1'b0;
                        halted   <= 1'b0;
                        load_err <= 1'b0;
                    end else if (bus.start) begin
                        if (loaded) begin
                            budget_cnt <= bus.run_cycles;
                            cycles_run <= '0;
                            halted     <= 1'b0;
                        end
                    end else if (bus.dbg_req) begin
                        drd_ret_halt <= (state == S_HALT);
                    end
                end
                S_LOAD: begin
                    if (bus.load_valid) begin
                        if (bus.load_last || ptr_max) begin
                            loaded   <= 1'b1;
                            load_err <= ~bus.load_last;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (cycles_run != '1) cycles_run <= cycles_run + 32'd1;
                    if (budget_cnt != '0) budget_cnt <= budget_cnt - 32'd1;
                    if (run_done) halted <= 1'b1;
                end
                S_DRD: begin
                    dbg_rdata <= bus.ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_rst    = (state != S_RUN);
    assign bus.load_ready = load_ready;
    assign bus.ram_we     = ram_we;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_wdata  = ram_wdata;
    assign bus.dbg_rdata  = dbg_rdata;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.loaded     = loaded;
    assign bus.load_err   = load_err;
    assign bus.halted     = halted;
    assign bus.cycles_run = cycles_run;

endmodule

// File: tb/tb_vscpu_sys_ctrl.sv
// Self-checking bench for vscpu_sys_ctrl with a behavioural single-port RAM.
module tb_vscpu_sys_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] mem [0:DEPTH-1];

    vscpu_sys_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    vscpu_sys_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: write on we, read data one cycle after address
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    typedef struct {
        logic [31:0] budget;
        int          stop_at;
        int          exp_low;
        logic [31:0] exp_cyc;
        bit          do_write;
    } run_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp_data;
    } dbg_vec_t;

    run_vec_t    rv [6];
    dbg_vec_t    dv [3];
    logic [31:0] words [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_run(input run_vec_t v);
        int low;
        low = 0;
        bus.run_cycles = v.budget;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.run_cycles = 32'hDEAD_BEEF;
        check("run_entry_cpu_rst", bus.cpu_rst, 0);
        check("run_entry_halted", bus.halted, 0);
        check("run_entry_cycles", bus.cycles_run, 0);
        for (int k = 0; k < 300; k++) begin
            if (bus.cpu_rst) break;
            low++;
            bus.stop = (low == v.stop_at);
            if (v.do_write && low == 1) begin
                bus.cpu_we = 1'b1;
                bus.cpu_addr = 14'd1;
                bus.cpu_wdata = 32'd5;
                settle();
                check("run_ram_we", bus.ram_we, 1);
                check("run_ram_addr", bus.ram_addr, 1);
                check("run_ram_wdata", bus.ram_wdata, 5);
            end else begin
                bus.cpu_we = 1'b0;
                bus.cpu_addr = low[AW-1:0];
                bus.cpu_wdata = '0;
            end
            step();
        end
        bus.stop = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        check("run_low_cycles", low, v.exp_low);
        check("run_halted", bus.halted, 1);
        check("run_cycles_run", bus.cycles_run, v.exp_cyc);
        step();
        check("halt_hold_cpu_rst", bus.cpu_rst, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        words[0] = 32'h9000_4005;
        words[1] = 32'h1234_5678;
        words[2] = 32'hAAAA_5555;
        rv[0] = '{32'd20, 0, 20, 32'd20, 1'b1};
        rv[1] = '{32'd1,  0, 1,  32'd1,  1'b0};
        rv[2] = '{32'd3,  0, 3,  32'd3,  1'b0};
        rv[3] = '{32'd0,  7, 7,  32'd7,  1'b0};
        rv[4] = '{32'd5,  5, 5,  32'd5,  1'b0};
        rv[5] = '{32'd9,  2, 2,  32'd2,  1'b0};
        dv[0] = '{14'd0, 32'h9000_4005};
        dv[1] = '{14'd1, 32'd5};
        dv[2] = '{14'd2, 32'hAAAA_5555};

        rst = 1'b1;
        bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
        bus.start = 0; bus.stop = 0; bus.run_cycles = '0;
        bus.dbg_req = 0; bus.dbg_addr = '0;
        bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        step(); step(); step();

        // reset values
        check("rst_cpu_rst", bus.cpu_rst, 1);
        check("rst_load_ready", bus.load_ready, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_dbg_rvalid", bus.dbg_rvalid, 0);
        check("rst_dbg_rdata", bus.dbg_rdata, 0);
        check("rst_loaded", bus.loaded, 0);
        check("rst_load_err", bus.load_err, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_cycles_run", bus.cycles_run, 0);
        rst = 1'b0;
        step();

        // start without an image is ignored
        bus.run_cycles = 32'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_unloaded_cpu_rst", bus.cpu_rst, 1);
        step();
        check("start_unloaded_cpu_rst2", bus.cpu_rst, 1);

        // three-word image
        bus.load_valid = 1'b1;
        bus.load_data = words[0];
        bus.load_last = 1'b0;
        settle();
        check("idle_load_ready", bus.load_ready, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            bus.load_data = words[i];
            bus.load_last = (i == 2);
            settle();
            check("load_ready", bus.load_ready, 1);
            check("load_ram_we", bus.ram_we, 1);
            check("load_ram_addr", bus.ram_addr, i);
            check("load_ram_wdata", bus.ram_wdata, words[i]);
            step();
        end
        bus.load_valid = 1'b0;
        bus.load_last = 1'b0;
        settle();
        check("load_done_ready", bus.load_ready, 0);
        check("load_done_loaded", bus.loaded, 1);
        check("load_done_err", bus.load_err, 0);
        check("load_done_cpu_rst", bus.cpu_rst, 1);
        for (int i = 0; i < 3; i++) check("load_mem", mem[i], words[i]);
        step();

        // run vectors
        for (int i = 0; i < 6; i++) do_run(rv[i]);
        check("run_mem1", mem[1], 32'd5);

        // debug reads from HALT
        for (int i = 0; i < 3; i++) begin
            bus.dbg_addr = dv[i].addr;
            bus.dbg_req = 1'b1;
            settle();
            check("dbg_req_ram_addr", bus.ram_addr, dv[i].addr);
            check("dbg_req_ram_we", bus.ram_we, 0);
            step();
            settle();
            check("dbg_drd_rvalid", bus.dbg_rvalid, 0);
            bus.dbg_req = 1'b0;
            step();
            check("dbg_rvalid", bus.dbg_rvalid, 1);
            check("dbg_rdata", bus.dbg_rdata, dv[i].exp_data);
            step();
            check("dbg_rvalid_pulse", bus.dbg_rvalid, 0);
            check("dbg_back_halted", bus.halted, 1);
        end

        // load_valid and start together in HALT: load wins
        bus.load_valid = 1'b1;
        bus.load_data = 32'h100;
        bus.start = 1'b1;
        bus.run_cycles = 32'd3;
        step();
        bus.start = 1'b0;
        settle();
        check("prio_halt_load_ready", bus.load_ready, 1);
        check("prio_halt_cpu_rst", bus.cpu_rst, 1);
        check("prio_halt_loaded", bus.loaded, 0);
        check("prio_halt_halted", bus.halted, 0);

        // rst during LOAD at word 4
        for (int i = 0; i < 4; i++) begin
            bus.load_data = 32'h100 + i;
            step();
        end
        bus.load_data = 32'h104;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.load_valid = 1'b0;
        settle();
        check("rst_load_ready_after", bus.load_ready, 0);
        check("rst_load_loaded", bus.loaded, 0);
        check("rst_load_cpu_rst", bus.cpu_rst, 1);
        bus.start = 1'b1;
        bus.run_cycles = 32'd5;
        step();
        bus.start = 1'b0;
        check("rst_start_ignored", bus.cpu_rst, 1);
        step(); step();
        check("rst_start_ignored2", bus.cpu_rst, 1);

        // overflow: 2^AW words without load_last
        begin
            int accepted;
            accepted = 0;
            bus.load_valid = 1'b1;
            bus.load_last = 1'b0;
            bus.load_data = 32'hC0DE_0000;
            step();
            for (int i = 0; i < DEPTH; i++) begin
                bus.load_data = 32'hC0DE_0000 | i;
                settle();
                if (bus.load_ready && bus.ram_we) accepted++;
                if (i == DEPTH - 1) begin
                    check("ovf_last_addr", bus.ram_addr, DEPTH - 1);
                    check("ovf_last_we", bus.ram_we, 1);
                end
                step();
            end
            bus.load_valid = 1'b0;
            settle();
            check("ovf_accepted", accepted, DEPTH);
            check("ovf_load_ready", bus.load_ready, 0);
            check("ovf_loaded", bus.loaded, 1);
            check("ovf_load_err", bus.load_err, 1);
            step();
            check("ovf_mem0", mem[0], 32'hC0DE_0000);
            check("ovf_mem_top", mem[DEPTH-1], 32'hC0DE_3FFF);
        end

        // load_valid and start together in IDLE: load wins
        bus.load_valid = 1'b1;
        bus.start = 1'b1;
        bus.run_cycles = 32'd3;
        step();
        bus.start = 1'b0;
        bus.load_valid = 1'b0;
        settle();
        check("prio_idle_load_ready", bus.load_ready, 1);
        check("prio_idle_cpu_rst", bus.cpu_rst, 1);
        check("prio_idle_loaded", bus.loaded, 0);
        step();
        check("prio_idle_no_run", bus.cpu_rst, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
